as2650_bus_responder: RTL and testbench
=======================================

# as2650_bus_responder

Slave-side responder for the AS2650 external bus. It decodes processor bus cycles (opreq, adr, m_io, rw, d_c), serves a register-based memory window and a small I/O port set, and returns opack after a programmable number of wait states. It sits on the padframe side opposite the CPU core, either on-chip for self-test or as the reference model for board-level peripherals.

## Interface
Parameters:
- MEM_AW, 8: memory window address width; depth 2^MEM_AW bytes.
- MEM_BASE, 13'h0000: window base; selects when adr[12:MEM_AW] == MEM_BASE[12:MEM_AW].
- IO_BASE, 8'h00: base of the 4-port I/O block; port selected when adr[7:2] == IO_BASE[7:2].
- WAIT_STATES, 1: wait cycles before acknowledge, 0..15.

Ports (one clock `clk`; reset `reset` is asynchronous, active-high):
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  async active-high reset.
- opreq  in  1  operation request from core, active-high.
- adr  in  13  address.
- m_io  in  1  1 = memory cycle, 0 = I/O cycle.
- d_c  in  1  I/O only: 1 = extended data port (uses adr[7:0]), 0 = control port.
- rw  in  1  1 = write, 0 = read.
- wrp  in  1  write pulse; accepted but unused (write commit is rw-based).
- dbus_in  in  8  write data from core.
- dbus_out  out  8  read data to core.
- dbus_oe  out  1  high while dbus_out is driven.
- opack  out  1  acknowledge, active-high, one cycle.
- sense  out  1  sense line to core.
- gpio_in  in  8  external input port (asynchronous).
- gpio_out  out  8  output latch.

## Operation
- Select: sel_mem = opreq & m_io & window match; sel_io = opreq & ~m_io & (d_c ? port match : 1). Unselected cycles are ignored entirely (no opack, dbus_oe low).
- I/O map (offset = adr[1:0]; control cycles d_c=0 always hit offset 2):
  - 0: gpio_out latch, R/W.
  - 1: gpio_in via 2-FF synchronizer, read-only; writes dropped.
  - 2: control; bit0 drives sense, bits 7:1 scratch, R/W.
  - 3: wait-state readback {4'h0, WAIT_STATES[3:0]}, read-only.
- FSM states IDLE, WAIT, ACK, HOLD:
  - IDLE: on sel_mem|sel_io, load wait counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else ACK.
  - WAIT: decrement counter; at count reaching 0 go ACK. opreq low -> IDLE (abort, no write, no opack).
  - ACK: opack=1 for exactly one cycle; go HOLD.
  - HOLD: dbus_oe stays high for reads; opreq low -> IDLE. Stays indefinitely while opreq high.
- Write commit (memory byte or I/O register) and read-data capture into dbus_out both happen on the edge that enters ACK, using bus values sampled on that edge.
- Reset: state IDLE, opack 0, dbus_oe 0, dbus_out 8'h00, gpio_out 8'h00, control 8'h00 (sense 0), synchronizer 0. Memory array not cleared. Reset mid-cycle aborts with no write.

## Timing
- Edge k: IDLE first samples selected opreq. opack high in cycle after edge k+WAIT_STATES, low after edge k+WAIT_STATES+1.
- Read data valid and dbus_oe high in same cycle as opack; held until the edge sampling opreq low in HOLD.
- Minimum request-to-request spacing: WAIT_STATES+3 edges (opreq must be seen low once in HOLD before a new cycle is accepted).
- gpio_in latency to readable value: 2 edges.
- Attributes (adr, m_io, rw, d_c, dbus_in) must be stable from opreq rise until opack sampled; changes during WAIT are not tracked except opreq drop.

## Test plan
- WAIT_STATES=1: write 8'hA5 to mem 13'h0010, then read 13'h0010 -> opack exactly 2 edges after opreq sample, dbus_out=8'hA5 with dbus_oe=1.
- WAIT_STATES=0: read back-to-back at 13'h0000/13'h00FF after writes 8'h11/8'h22 -> opack 1 edge after sample, data 8'h11 then 8'h22, one idle HOLD->IDLE gap.
- I/O extended write port IO_BASE+0 = 8'h3C -> gpio_out=8'h3C; gpio_in=8'h5A, read offset 1 after 2 edges -> 8'h5A; write offset 1 ignored.
- Control write (d_c=0) 8'h01 -> sense=1; read offset 3 -> 8'h01 for WAIT_STATES=1.
- Address 13'h0100 (outside MEM_AW=8 window) -> no opack, dbus_oe 0 for 20 cycles; opreq dropped during WAIT -> no write, state IDLE.
- Assert reset during WAIT of a write to 13'h0020 (prior value 8'h77) -> opack never asserts, gpio_out/sense cleared, later read returns 8'h77.

Source files
------------

// File: rtl/as2650_bus_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | as2650_bus_responder: AS2650 bus slave with memory window, I/O ports    |
// | and programmable wait states.                        Revision: 1.0      |
// +-------------------------------------------------------------------------+
module as2650_bus_responder #(
  parameter int          MEM_AW      = 8,
  parameter logic [12:0] MEM_BASE    = 13'h0000,
  parameter logic [7:0]  IO_BASE     = 8'h00,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opreq,
  input  logic [12:0] adr,
  input  logic        m_io,
  input  logic        d_c,
  input  logic        rw,
  input  logic        wrp,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  output logic        opack,
  output logic        sense,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        enter_ack;
  logic [3:0]  cnt;
  logic        rd_flag;
  logic [7:0]  ctrl;
  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  rdata;
  logic [1:0]  io_off;
  logic        sel_mem;
  logic        sel_io;
  logic        sel_any;
  logic [7:0]  mem [2**MEM_AW];

  // Write strobe is accepted for bus compatibility; commits key off rw.
  logic unused_wrp;
  assign unused_wrp = wrp;

  assign sel_mem = opreq & m_io & (adr[12:MEM_AW] == MEM_BASE[12:MEM_AW]);
  assign sel_io  = opreq & ~m_io & (d_c ? (adr[7:2] == IO_BASE[7:2]) : 1'b1);
  assign sel_any = sel_mem | sel_io;
  // Control cycles have no address of their own and always land on the control register.
  assign io_off  = d_c ? adr[1:0] : 2'd2;

  always_comb begin
    rdata = 8'h00;
    if (m_io) begin
      rdata = mem[adr[MEM_AW-1:0]];
    end else begin
      case (io_off)
        2'd0:    rdata = gpio_out;
        2'd1:    rdata = sync2;
        2'd2:    rdata = ctrl;
        default: rdata = {4'h0, WS};
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    enter_ack = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_any) begin
          if (WS != 4'd0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!opreq) begin
          state_nxt = S_IDLE;
        end else if (cnt <= 4'd1) begin
          state_nxt = S_ACK;
          enter_ack = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_HOLD;
      default: if (!opreq) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rd_flag  <= 1'b0;
      dbus_out <= 8'h00;
      gpio_out <= 8'h00;
      ctrl     <= 8'h00;
      sync1    <= 8'h00;
      sync2    <= 8'h00;
    end else begin
      state <= state_nxt;
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (state == S_IDLE && sel_any) begin
        cnt <= WS;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack) begin
        rd_flag <= ~rw;
        if (!rw) begin
          dbus_out <= rdata;
        end else if (!m_io) begin
          case (io_off)
            2'd0:    gpio_out <= dbus_in;
            2'd2:    ctrl     <= dbus_in;
            default: ;
          endcase
        end
      end
    end
  end

  // Array has no reset; gate with reset so an aborted cycle never commits.
  always_ff @(posedge clk) begin
    if (enter_ack && rw && m_io && !reset) begin
      mem[adr[MEM_AW-1:0]] <= dbus_in;
    end
  end

  assign opack   = (state == S_ACK);
  assign dbus_oe = rd_flag & ((state == S_ACK) | (state == S_HOLD));
  assign sense   = ctrl[0];

endmodule
`default_nettype wire

// File: tb/tb_as2650_bus_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_as2650_bus_responder: scoreboard bench for two responder instances   |
// | (WAIT_STATES=1 and WAIT_STATES=0).                   Revision: 1.0      |
// +-------------------------------------------------------------------------+
module tb_as2650_bus_responder;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        opreq_w1 = 1'b0;
  logic        opreq_w0 = 1'b0;
  logic [12:0] adr = 13'h0;
  logic        m_io = 1'b0;
  logic        d_c = 1'b0;
  logic        rw = 1'b0;
  logic        wrp = 1'b0;
  logic [7:0]  dbus_in = 8'h0;
  logic [7:0]  gpio_in = 8'h0;

  logic [7:0]  dbus_out_w1, dbus_out_w0, gpio_out_w1, gpio_out_w0;
  logic        dbus_oe_w1, dbus_oe_w0, opack_w1, opack_w0, sense_w1, sense_w0;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t q_w1[$];
  exp_t q_w0[$];
  logic prev_w1 = 1'b0;
  logic prev_w0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  as2650_bus_responder #(.MEM_AW(8), .MEM_BASE(13'h0000), .IO_BASE(8'h00), .WAIT_STATES(1)) dut_w1 (
    .clk(clk), .reset(reset), .opreq(opreq_w1), .adr(adr), .m_io(m_io), .d_c(d_c),
    .rw(rw), .wrp(wrp), .dbus_in(dbus_in), .dbus_out(dbus_out_w1), .dbus_oe(dbus_oe_w1),
    .opack(opack_w1), .sense(sense_w1), .gpio_in(gpio_in), .gpio_out(gpio_out_w1)
  );

  as2650_bus_responder #(.MEM_AW(8), .MEM_BASE(13'h0000), .IO_BASE(8'h00), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(reset), .opreq(opreq_w0), .adr(adr), .m_io(m_io), .d_c(d_c),
    .rw(rw), .wrp(wrp), .dbus_in(dbus_in), .dbus_out(dbus_out_w0), .dbus_oe(dbus_oe_w0),
    .opack(opack_w0), .sense(sense_w0), .gpio_in(gpio_in), .gpio_out(gpio_out_w0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every opack pops one expected transaction and checks it.
  task automatic mon(input int d, input logic ack, input logic prev, input logic oe, input logic [7:0] dout);
    exp_t e;
    if (!ack) return;
    check($sformatf("opack_single_cycle_%0d", d), {31'd0, prev}, 32'd0);
    if ((d == 1 && q_w1.size() == 0) || (d == 0 && q_w0.size() == 0)) begin
      check($sformatf("unexpected_opack_%0d", d), 32'd1, 32'd0);
      return;
    end
    e = (d == 1) ? q_w1.pop_front() : q_w0.pop_front();
    check($sformatf("ack_edge_%0d", d), cyc, e.edge_no);
    check($sformatf("dbus_oe_%0d", d), {31'd0, oe}, {31'd0, e.rd});
    if (e.rd) check($sformatf("rdata_%0d", d), {24'd0, dout}, {24'd0, e.data});
  endtask

  always @(negedge clk) begin
    mon(1, opack_w1, prev_w1, dbus_oe_w1, dbus_out_w1);
    mon(0, opack_w0, prev_w0, dbus_oe_w0, dbus_out_w0);
    prev_w1 = opack_w1;
    prev_w0 = opack_w0;
  end

  task automatic bus(input int d, input logic mio, input logic dc, input logic wr,
                     input logic [12:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
    exp_t e;
    logic got;
    @(negedge clk);
    adr = a; m_io = mio; d_c = dc; rw = wr; dbus_in = wd;
    e.rd = ~wr;
    e.data = exp_rd;
    e.edge_no = cyc + 1 + ((d == 1) ? 1 : 0);
    if (d == 1) begin q_w1.push_back(e); opreq_w1 = 1'b1; end
    else        begin q_w0.push_back(e); opreq_w0 = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (d == 1) ? opack_w1 : opack_w0;
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (d == 1 && q_w1.size() > 0) void'(q_w1.pop_front());
      if (d == 0 && q_w0.size() > 0) void'(q_w0.pop_front());
    end
    @(negedge clk);
    opreq_w1 = 1'b0;
    opreq_w0 = 1'b0;
    @(negedge clk);
  endtask

  // Holds an unselected request on dut_w1 and counts any response.
  task automatic no_ack(input string name, input logic mio, input logic dc, input logic [12:0] a);
    int seen;
    @(negedge clk);
    adr = a; m_io = mio; d_c = dc; rw = 1'b0; opreq_w1 = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (opack_w1 || dbus_oe_w1) seen++;
    end
    opreq_w1 = 1'b0;
    check(name, seen, 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst_opack", {30'd0, opack_w1, opack_w0}, 32'd0);
    check("rst_oe", {30'd0, dbus_oe_w1, dbus_oe_w0}, 32'd0);
    check("rst_dout", {16'd0, dbus_out_w1, dbus_out_w0}, 32'd0);
    check("rst_gpio_out", {16'd0, gpio_out_w1, gpio_out_w0}, 32'd0);
    check("rst_sense", {30'd0, sense_w1, sense_w0}, 32'd0);
    reset = 1'b0;

    // One wait state: memory write then read.
    bus(1, 1'b1, 1'b0, 1'b1, 13'h0010, 8'hA5, 8'h00);
    bus(1, 1'b1, 1'b0, 1'b0, 13'h0010, 8'h00, 8'hA5);

    // Zero wait states: back-to-back accesses at the window edges.
    bus(0, 1'b1, 1'b0, 1'b1, 13'h0000, 8'h11, 8'h00);
    bus(0, 1'b1, 1'b0, 1'b1, 13'h00FF, 8'h22, 8'h00);
    bus(0, 1'b1, 1'b0, 1'b0, 13'h0000, 8'h00, 8'h11);
    bus(0, 1'b1, 1'b0, 1'b0, 13'h00FF, 8'h00, 8'h22);

    // I/O ports.
    bus(1, 1'b0, 1'b1, 1'b1, 13'h0000, 8'h3C, 8'h00);
    check("gpio_out", {24'd0, gpio_out_w1}, 32'h3C);
    bus(1, 1'b0, 1'b1, 1'b0, 13'h0000, 8'h00, 8'h3C);
    gpio_in = 8'h5A;
    repeat (2) @(negedge clk);
    bus(1, 1'b0, 1'b1, 1'b0, 13'h0001, 8'h00, 8'h5A);
    bus(1, 1'b0, 1'b1, 1'b1, 13'h0001, 8'hFF, 8'h00);
    bus(1, 1'b0, 1'b1, 1'b0, 13'h0001, 8'h00, 8'h5A);
    bus(1, 1'b0, 1'b0, 1'b1, 13'h1FFF, 8'h01, 8'h00);
    check("sense", {31'd0, sense_w1}, 32'd1);
    bus(1, 1'b0, 1'b1, 1'b0, 13'h0002, 8'h00, 8'h01);
    bus(1, 1'b0, 1'b1, 1'b0, 13'h0003, 8'h00, 8'h01);
    bus(0, 1'b0, 1'b1, 1'b0, 13'h0003, 8'h00, 8'h00);

    // Unselected cycles.
    no_ack("outside_window", 1'b1, 1'b0, 13'h0100);
    no_ack("outside_io_block", 1'b0, 1'b1, 13'h0004);

    // Abort during WAIT: no write, responder returns to idle.
    bus(1, 1'b1, 1'b0, 1'b1, 13'h0030, 8'h44, 8'h00);
    @(negedge clk);
    adr = 13'h0030; m_io = 1'b1; rw = 1'b1; dbus_in = 8'hEE; opreq_w1 = 1'b1;
    @(negedge clk);
    opreq_w1 = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (opack_w1) seen++; end
    check("abort_no_ack", seen, 32'd0);
    bus(1, 1'b1, 1'b0, 1'b0, 13'h0030, 8'h00, 8'h44);

    // Reset in the middle of a write.
    bus(1, 1'b1, 1'b0, 1'b1, 13'h0020, 8'h77, 8'h00);
    @(negedge clk);
    adr = 13'h0020; m_io = 1'b1; rw = 1'b1; dbus_in = 8'h99; opreq_w1 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (3) begin @(negedge clk); if (opack_w1) seen++; end
    check("rst_gpio_cleared", {24'd0, gpio_out_w1}, 32'd0);
    check("rst_sense_cleared", {31'd0, sense_w1}, 32'd0);
    opreq_w1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (opack_w1) seen++; end
    check("rst_no_ack", seen, 32'd0);
    bus(1, 1'b1, 1'b0, 1'b0, 13'h0020, 8'h00, 8'h77);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q_w1.size() + q_w0.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
